// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the RISC Toy pipeline sequencer:
//   - state_e      : sequencer state encodings (RUN / LSTALL / MWAIT)
//   - OP_*         : decode opcode constants (loads, stores, jumps)
//   - is_load/is_store/is_jump : opcode classification helpers for decode
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_e;

    localparam logic [4:0] OP_LOAD_W  = 5'b10011;
    localparam logic [4:0] OP_LOAD_B  = 5'b10100;
    localparam logic [4:0] OP_STORE_W = 5'b10101;
    localparam logic [4:0] OP_STORE_B = 5'b10110;
    localparam logic [4:0] OP_JMP_0   = 5'b10000;
    localparam logic [4:0] OP_JMP_1   = 5'b10001;
    localparam logic [4:0] OP_JMP_2   = 5'b10010;

    function automatic logic is_load(input logic [4:0] op);
        return (op == OP_LOAD_W) || (op == OP_LOAD_B);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == OP_STORE_W) || (op == OP_STORE_B);
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return (op == OP_JMP_0) || (op == OP_JMP_1) || (op == OP_JMP_2);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at MAX. clr has priority over inc.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : increment by one unless already at MAX
//   clr        : synchronous clear to zero
//   count      : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W   = 16,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencer for the 5-stage RISC Toy core. Resolves memory-wait
// freezes, branch/jump redirect flushes and load-use stalls (in that priority)
// and drives per-stage write enables, flushes and the PC redirect select.
// All stage controls are combinational (Mealy) from state and inputs.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_ra/id_rb, id_uses_ra/rb : ID source registers and their use flags
//   ex_memread, ex_rd          : EX instruction is a load, and its destination
//   ex_branch_taken, ex_jump   : EX control-flow change
//   mem_req, mem_ready         : data-memory handshake from MEM
//   pc_write..memwb_write      : stage enables / flushes / PC mux select
//   mem_error                  : sticky memory-timeout flag
//   stall_count, flush_count   : saturating statistics
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [9:0] WAIT_MAX  = 10'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       err_q;
    logic [9:0] wait_cnt;

    logic mem_busy, redirect, lu_hit, stall_pending;
    logic stall_inc, flush_inc;

    assign mem_busy = mem_req & ~mem_ready;
    assign redirect = ex_branch_taken | ex_jump;
    assign lu_hit   = ex_memread & ((id_uses_ra & (id_ra == ex_rd)) |
                                    (id_uses_rb & (id_rb == ex_rd)));

    // A load-use stall interrupted by a freeze parks in MWAIT with its
    // remaining count intact and resumes once memory completes.
    assign stall_pending = (state_q == ST_LSTALL) ||
                           ((state_q == ST_MWAIT) && (rem_q != 3'd0));

    always_comb begin
        state_d     = ST_RUN;
        rem_d       = rem_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_write    = 1'b1;
        pc_redirect = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        memwb_write = 1'b1;

        if (mem_busy) begin
            // Freeze: hold every pipeline register, keep the stall count.
            state_d     = ST_MWAIT;
            stall_inc   = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (redirect) begin
            // The ID instruction is flushed, so any load-use hit is moot.
            state_d     = ST_RUN;
            rem_d       = 3'd0;
            flush_inc   = 1'b1;
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (stall_pending) begin
            rem_d       = rem_q - 3'd1;
            state_d     = (rem_q > 3'd1) ? ST_LSTALL : ST_RUN;
            stall_inc   = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end else if (lu_hit) begin
            rem_d       = LS_RELOAD;
            state_d     = (LS_RELOAD != 3'd0) ? ST_LSTALL : ST_RUN;
            stall_inc   = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end

        // Pipeline is fully quiescent while reset is asserted.
        if (!rst_n) begin
            pc_write    = 1'b0;
            pc_redirect = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_write  = 1'b0;
            idex_flush  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            // Sets on the edge where the wait count reaches MEM_TIMEOUT.
            if (mem_busy && (wait_cnt == WAIT_MAX - 10'd1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_error = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (1'b0),
        .count (flush_count)
    );

    sat_counter #(.W(10), .MAX(WAIT_MAX)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_busy),
        .clr   (~mem_busy),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two sequencers share one stimulus stream: dut_a uses one bubble per load-use
// and the default timeout; dut_b uses three bubbles and an 8-cycle timeout.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
// Stage controls are packed as {pc_write, pc_redirect, ifid_write, ifid_flush,
// idex_write, idex_flush, exmem_write, memwb_write}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] O_NORM  = 8'b1010_1011;
    localparam logic [7:0] O_STALL = 8'b0000_1111;
    localparam logic [7:0] O_REDIR = 8'b1111_1111;
    localparam logic [7:0] O_OFF   = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_ra, id_rb, ex_rd;
    logic id_uses_ra, id_uses_rb, ex_memread, ex_branch_taken, ex_jump;
    logic mem_req, mem_ready;

    logic a_pcw, a_pcr, a_ifw, a_iff, a_idw, a_idf, a_exw, a_mww, a_err;
    logic b_pcw, b_pcr, b_ifw, b_iff, b_idw, b_idf, b_exw, b_mww, b_err;
    logic [15:0] a_stall, a_flush, b_stall, b_flush;
    logic [7:0] outs_a, outs_b;

    assign outs_a = {a_pcw, a_pcr, a_ifw, a_iff, a_idw, a_idf, a_exw, a_mww};
    assign outs_b = {b_pcw, b_pcr, b_ifw, b_iff, b_idw, b_idf, b_exw, b_mww};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(a_pcw), .pc_redirect(a_pcr), .ifid_write(a_ifw), .ifid_flush(a_iff),
        .idex_write(a_idw), .idex_flush(a_idf), .exmem_write(a_exw), .memwb_write(a_mww),
        .mem_error(a_err), .stall_count(a_stall), .flush_count(a_flush)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(b_pcw), .pc_redirect(b_pcr), .ifid_write(b_ifw), .ifid_flush(b_iff),
        .idex_write(b_idw), .idex_flush(b_idf), .exmem_write(b_exw), .memwb_write(b_mww),
        .mem_error(b_err), .stall_count(b_stall), .flush_count(b_flush)
    );

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        id_ra = 5'd0; id_rb = 5'd0; ex_rd = 5'd0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic load_use_ra5();
        ex_memread = 1'b1; ex_rd = 5'd5; id_ra = 5'd5; id_uses_ra = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        settle();
        check_eq({tag, "_rst_outs_a"}, {24'd0, outs_a}, {24'd0, O_OFF});
        check_eq({tag, "_rst_outs_b"}, {24'd0, outs_b}, {24'd0, O_OFF});
        check_eq({tag, "_rst_err_b"}, {31'd0, b_err}, 32'd0);
        check_eq({tag, "_rst_stall_b"}, {16'd0, b_stall}, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();

        // Reset then idle.
        do_reset("init");
        settle();
        check_eq("idle_outs_a", {24'd0, outs_a}, {24'd0, O_NORM});
        check_eq("idle_outs_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("idle_stall_a", {16'd0, a_stall}, 32'd0);
        check_eq("idle_flush_a", {16'd0, a_flush}, 32'd0);
        check_eq("idle_err_a", {31'd0, a_err}, 32'd0);

        // Load-use through ra: one bubble on a, three on b.
        next_cycle();
        load_use_ra5();
        settle();
        check_eq("lu1_a", {24'd0, outs_a}, {24'd0, O_STALL});
        check_eq("lu1_b", {24'd0, outs_b}, {24'd0, O_STALL});
        next_cycle();
        clear_inputs();
        settle();
        check_eq("lu2_a", {24'd0, outs_a}, {24'd0, O_NORM});
        check_eq("lu2_stall_a", {16'd0, a_stall}, 32'd1);
        check_eq("lu2_b", {24'd0, outs_b}, {24'd0, O_STALL});
        next_cycle();
        settle();
        check_eq("lu3_b", {24'd0, outs_b}, {24'd0, O_STALL});
        next_cycle();
        settle();
        check_eq("lu4_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("lu4_stall_b", {16'd0, b_stall}, 32'd3);

        // Matching ra without the use flag: no hazard.
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_ra = 5'd5; id_uses_ra = 1'b0;
        settle();
        check_eq("nouse_a", {24'd0, outs_a}, {24'd0, O_NORM});

        // rb = r0 hit: r0 gets no exemption.
        next_cycle();
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rb = 5'd0; id_uses_rb = 1'b1;
        settle();
        check_eq("rb_r0_a", {24'd0, outs_a}, {24'd0, O_STALL});

        // Taken branch together with a load-use hit: redirect wins.
        next_cycle();
        do_reset("br");
        load_use_ra5();
        ex_branch_taken = 1'b1;
        settle();
        check_eq("br_a", {24'd0, outs_a}, {24'd0, O_REDIR});
        check_eq("br_b", {24'd0, outs_b}, {24'd0, O_REDIR});
        next_cycle();
        clear_inputs();
        settle();
        check_eq("br_next_a", {24'd0, outs_a}, {24'd0, O_NORM});
        check_eq("br_next_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("br_flush_a", {16'd0, a_flush}, 32'd1);
        check_eq("br_stall_a", {16'd0, a_stall}, 32'd0);
        check_eq("br_stall_b", {16'd0, b_stall}, 32'd0);

        // Four freeze cycles then completion.
        do_reset("frz");
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("frz%0d_a", i), {24'd0, outs_a}, {24'd0, O_OFF});
            next_cycle();
        end
        mem_ready = 1'b1;
        settle();
        check_eq("frz_rel_a", {24'd0, outs_a}, {24'd0, O_NORM});
        check_eq("frz_stall_a", {16'd0, a_stall}, 32'd4);
        check_eq("frz_err_a", {31'd0, a_err}, 32'd0);
        check_eq("frz_err_b", {31'd0, b_err}, 32'd0);
        next_cycle();

        // Timeout on b: error visible once 8 busy edges have passed.
        do_reset("tmo");
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_eq($sformatf("tmo%0d_b", i), {24'd0, outs_b}, {24'd0, O_OFF});
            check_eq($sformatf("tmo%0d_err_b", i), {31'd0, b_err}, (i >= 8) ? 32'd1 : 32'd0);
            next_cycle();
        end
        mem_ready = 1'b1;
        settle();
        check_eq("tmo_rel_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("tmo_rel_err_b", {31'd0, b_err}, 32'd1);
        check_eq("tmo_err_a", {31'd0, a_err}, 32'd0);
        check_eq("tmo_stall_a", {16'd0, a_stall}, 32'd10);
        next_cycle();
        clear_inputs();
        settle();
        check_eq("tmo_sticky_b", {31'd0, b_err}, 32'd1);
        next_cycle();
        do_reset("tmo_clr");

        // Freeze in the 2nd stall cycle on b: stall count is preserved.
        load_use_ra5();
        settle();
        check_eq("mix1_b", {24'd0, outs_b}, {24'd0, O_STALL});
        next_cycle();
        clear_inputs();
        mem_req = 1'b1; mem_ready = 1'b0;
        settle();
        check_eq("mix2_b", {24'd0, outs_b}, {24'd0, O_OFF});
        check_eq("mix2_a", {24'd0, outs_a}, {24'd0, O_OFF});
        next_cycle();
        mem_ready = 1'b1;
        settle();
        check_eq("mix3_b", {24'd0, outs_b}, {24'd0, O_STALL});
        check_eq("mix3_a", {24'd0, outs_a}, {24'd0, O_NORM});
        next_cycle();
        clear_inputs();
        settle();
        check_eq("mix4_b", {24'd0, outs_b}, {24'd0, O_STALL});
        next_cycle();
        settle();
        check_eq("mix5_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("mix5_stall_b", {16'd0, b_stall}, 32'd4);

        // Jump cancels a pending stall on b.
        next_cycle();
        load_use_ra5();
        next_cycle();
        clear_inputs();
        ex_jump = 1'b1;
        settle();
        check_eq("jcan_b", {24'd0, outs_b}, {24'd0, O_REDIR});
        next_cycle();
        clear_inputs();
        settle();
        check_eq("jcan_next_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("jcan_flush_b", {16'd0, b_flush}, 32'd1);

        // Reset pulse in the middle of an LSTALL on b.
        next_cycle();
        load_use_ra5();
        next_cycle();
        do_reset("midrst");
        settle();
        check_eq("midrst_b", {24'd0, outs_b}, {24'd0, O_NORM});
        check_eq("midrst_stall_b", {16'd0, b_stall}, 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
